adder_share_ctrl: RTL and testbench
===================================

Name: adder_share_ctrl

Overview:
- Round-robin controller that shares one 64-bit add/sub datapath between NREQ requesters.
- Each requester presents operands over a valid/ready handshake; the block arbitrates, registers operands, executes one add/sub, and returns the result on a single tagged response channel with valid/ready.
- Sits between the issuing units and the shared fast adder.
- The adder is instantiated inside this block.

Parameters:
- W, 64, operand/result width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width, equal to clog2(NREQ).
- CNTW, 32, width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  NREQ*W  flattened operand A; requester i occupies [i*W +: W].
- req_b  in  NREQ*W  flattened operand B.
- req_cin  in  NREQ  per-requester carry-in.
- req_op  in  NREQ  per-requester operation: 0 = add, 1 = subtract.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  W  result.
- rsp_carry  out  1  carry-out.
- busy  out  1  high in EXEC and RESP.
- op_count  out  CNTW  completed responses; wraps modulo 2^CNTW.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy=0, op_count=0, req_ready=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority after reset.
- States IDLE, EXEC, RESP.
  - IDLE: if any req_valid, grant g = first valid index searching last+1, last+2, ... modulo NREQ.
    - req_ready[g]=1 combinationally in the same cycle (a single bit).
    - On that edge: latch a, b, cin, op, id=g; last<=g; go to EXEC.
    - With no req_valid, remain in IDLE with req_ready=0.
  - EXEC: the adder computes from the registered operands. On the edge, capture sum and carry into the rsp_* registers, set rsp_valid=1, go to RESP. req_ready=0.
  - RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
    - When rsp_valid and rsp_ready are both high: rsp_valid<=0, op_count<=op_count+1, go to IDLE.
    - req_ready=0 throughout RESP.
- Latency: accept in cycle T, rsp_valid high from cycle T+2. Minimum issue interval is 3 cycles.
- Arithmetic:
  - b_eff = op ? (~b + 1) mod 2^W : b.
  - {carry, sum} = a + b_eff + cin, using a W+1-bit result.
  - Subtract with b=0 gives b_eff=0, hence carry=0.
- The pointer advances only on an accepted request; idle cycles do not rotate priority.
- req_valid dropping before grant: no effect, and nothing is latched.
- The requester must hold its operands stable only during the handshake cycle.
- rsp_ready high while rsp_valid is low is ignored.
- rst asserted mid-operation (EXEC or RESP): the in-flight operation is discarded with no response. op_count is not incremented.
- Only one operation is in flight; requests arriving during EXEC or RESP wait.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
  - OP_ADD=1'b0, OP_SUB=1'b1.
  - default W, NREQ.
- One sub-module: rr_arbiter (combinational).
  - Inputs: req vector and last pointer.
  - Outputs: grant index and any_req.
- The FSM, operand registers, adder instance and counter stay in adder_share_ctrl.

Test Plan:
1. Single add: req0 a=5, b=3, cin=0, op=0, rsp_ready=1.
   -> req_ready[0] in cycle T; rsp_valid at T+2 with sum=8, carry=0, id=0; op_count=1.
2. Subtract and boundaries:
   - req2 a=5, b=3, op=1 -> sum=2, carry=1.
   - a=0, b=1, op=1 -> sum=64'hFFFF_FFFF_FFFF_FFFF, carry=0.
   - a=5, b=0, op=1 -> sum=5, carry=0.
   - a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=1, op=0 -> sum=1, carry=1.
3. Round-robin fairness: all four req_valid held high continuously.
   -> grants in order 0, 1, 2, 3, 0, 1; each response carries the matching rsp_id; no starvation.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
   -> rsp_sum, rsp_carry, rsp_id stable; req_ready stays 0; op_count unchanged until the handshake.
5. Reset mid-operation: assert rst during EXEC.
   -> rsp_valid=0 and op_count=0 immediately (asynchronous); after release, requester 0 wins first arbitration.
6. Pointer hold: grant requester 1, idle 4 cycles, then requesters 0 and 2 valid together.
   -> requester 2 granted first, then requester 0.

Source files
------------

// File: rtl/adder_share_ctrl_pkg.sv
// Shared definitions for the shared add/sub controller: FSM state
// encoding, operation codes, default sizing and a ring-index helper.
package adder_share_ctrl_pkg;

  localparam int DEFAULT_W    = 64;
  localparam int DEFAULT_NREQ = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Position 'offset' steps after 'base' on a ring of 'n' requesters.
  function automatic int wrapIndex(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requesting index
// strictly after the last granted one, wrapping around the ring.
module rr_arbiter
  import adder_share_ctrl_pkg::*;
#(
  parameter int NREQ = DEFAULT_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last,
  output logic [IDW-1:0]  o_grant,
  output logic            o_any_req
);

  // Walk the ring from the farthest position to the nearest so that the
  // nearest requester after the last grant overwrites any earlier pick.
  always_comb begin
    o_grant   = '0;
    o_any_req = 1'b0;
    for (int off = NREQ; off >= 1; off--) begin
      if (i_req[wrapIndex(int'(i_last), off, NREQ)]) begin
        o_grant   = IDW'(wrapIndex(int'(i_last), off, NREQ));
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing a single W-bit add/sub datapath among
// NREQ requesters; one operation in flight, tagged response channel.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int W    = DEFAULT_W,
  parameter int NREQ = DEFAULT_NREQ,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  input  logic [NREQ-1:0]   req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_sum,
  output logic              rsp_carry,
  output logic              busy,
  output logic [CNTW-1:0]   op_count
);

  state_t          r_state;
  state_t          w_nextState;

  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  w_grant;
  logic            w_anyReq;
  logic            w_accept;
  logic            w_rspFire;

  logic [W-1:0]    w_selA;
  logic [W-1:0]    w_selB;
  logic            w_selCin;
  logic            w_selOp;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_cin;
  logic            r_op;
  logic [IDW-1:0]  r_id;

  logic [W-1:0]    w_bEff;
  logic [W:0]      w_addRes;

  logic            r_rspValid;
  logic [IDW-1:0]  r_rspId;
  logic [W-1:0]    r_rspSum;
  logic            r_rspCarry;
  logic [CNTW-1:0] r_opCount;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req     (req_valid),
    .i_last    (r_last),
    .o_grant   (w_grant),
    .o_any_req (w_anyReq)
  );

  assign w_accept  = (r_state == ST_IDLE) && w_anyReq;
  assign w_rspFire = (r_state == ST_RESP) && r_rspValid && rsp_ready;

  // Route the granted requester's operand lanes to the capture registers.
  always_comb begin
    w_selA   = '0;
    w_selB   = '0;
    w_selCin = 1'b0;
    w_selOp  = OP_ADD;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_selA   = req_a[i*W +: W];
        w_selB   = req_b[i*W +: W];
        w_selCin = req_cin[i];
        w_selOp  = req_op[i];
      end
    end
  end

  // Shared adder: subtraction feeds the two's complement of B, so B=0
  // yields an effective operand of zero and therefore no carry-out.
  always_comb begin
    w_bEff = (r_op == OP_SUB) ? (~r_b + W'(1)) : r_b;
  end

  assign w_addRes = {1'b0, r_a} + {1'b0, w_bEff} + {{W{1'b0}}, r_cin};

  // Next-state and grant decode; only IDLE can hand out a ready.
  always_comb begin
    w_nextState = r_state;
    req_ready   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyReq) begin
          req_ready[w_grant] = 1'b1;
          w_nextState        = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_nextState = ST_RESP;
      end
      ST_RESP: begin
        if (r_rspValid && rsp_ready) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Operand capture and priority pointer, both updated only on a grant so
  // idle cycles never rotate priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_cin  <= 1'b0;
      r_op   <= OP_ADD;
      r_id   <= '0;
      r_last <= IDW'(NREQ - 1);
    end else if (w_accept) begin
      r_a    <= w_selA;
      r_b    <= w_selB;
      r_cin  <= w_selCin;
      r_op   <= w_selOp;
      r_id   <= w_grant;
      r_last <= w_grant;
    end
  end

  // Response registers: loaded at the end of EXEC, held through
  // backpressure, retired with a count bump on the response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rspValid <= 1'b0;
      r_rspId    <= '0;
      r_rspSum   <= '0;
      r_rspCarry <= 1'b0;
      r_opCount  <= '0;
    end else if (r_state == ST_EXEC) begin
      r_rspValid <= 1'b1;
      r_rspId    <= r_id;
      r_rspSum   <= w_addRes[W-1:0];
      r_rspCarry <= w_addRes[W];
    end else if (w_rspFire) begin
      r_rspValid <= 1'b0;
      r_opCount  <= r_opCount + CNTW'(1);
    end
  end

  assign rsp_valid = r_rspValid;
  assign rsp_id    = r_rspId;
  assign rsp_sum   = r_rspSum;
  assign rsp_carry = r_rspCarry;
  assign op_count  = r_opCount;
  assign busy      = (r_state == ST_EXEC) || (r_state == ST_RESP);

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl with a behavioural reference
// model of arbitration order, arithmetic and the completion count.
module tb_adder_share_ctrl;

  localparam int W    = 64;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int CNTW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_carry;
  logic              busy;
  logic [CNTW-1:0]   op_count;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] opA   [NREQ];
  logic [W-1:0] opB   [NREQ];
  logic         opCin [NREQ];
  logic         opOp  [NREQ];

  int          mLast;
  int unsigned mCount;

  always #5 clk = ~clk;

  adder_share_ctrl #(
    .W    (W),
    .NREQ (NREQ),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [NREQ-1:0] mask);
    req_valid = mask;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = opA[i];
      req_b[i*W +: W] = opB[i];
      req_cin[i]      = opCin[i];
      req_op[i]       = opOp[i];
    end
  endtask

  task automatic randomizeOperands();
    for (int i = 0; i < NREQ; i++) begin
      opA[i]   = {$urandom, $urandom};
      opB[i]   = {$urandom, $urandom};
      opCin[i] = 1'($urandom_range(0, 1));
      opOp[i]  = 1'($urandom_range(0, 1));
    end
  endtask

  // Next requester after 'last' on the ring that is asking.
  function automatic int refGrant(input int last, input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // {carry, sum} from plain modular arithmetic on a W+1 bit value.
  function automatic logic [W:0] refArith(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic op);
    logic [W:0] negB;
    logic [W:0] bEff;
    negB = (65'd1 << W) - {1'b0, b};
    bEff = op ? {1'b0, negB[W-1:0]} : {1'b0, b};
    return {1'b0, a} + bEff + {{W{1'b0}}, cin};
  endfunction

  // One full transaction, entered just after a rising edge with the DUT idle.
  task automatic doTransaction(input logic [NREQ-1:0] mask, input int bpCycles,
                               input bit keep, input string tag);
    int         g;
    logic [W:0] expRes;
    applyStimulus(mask);
    rsp_ready = (bpCycles == 0);
    g = refGrant(mLast, mask);
    expRes = refArith(opA[g], opB[g], opCin[g], opOp[g]);
    @(negedge clk);
    checkOutput({tag, ".ready"}, req_ready, NREQ'(1) << g);
    checkOutput({tag, ".idleBusy"}, busy, 0);
    @(posedge clk);
    #1;
    mLast = g;
    randomizeOperands();
    applyStimulus(keep ? mask : '0);
    @(negedge clk);
    checkOutput({tag, ".execBusy"}, busy, 1);
    checkOutput({tag, ".execReady"}, req_ready, 0);
    checkOutput({tag, ".execValid"}, rsp_valid, 0);
    @(negedge clk);
    checkOutput({tag, ".valid"}, rsp_valid, 1);
    checkOutput({tag, ".id"}, rsp_id, g);
    checkOutput({tag, ".sum"}, rsp_sum, expRes[W-1:0]);
    checkOutput({tag, ".carry"}, rsp_carry, expRes[W]);
    checkOutput({tag, ".count"}, op_count, mCount);
    for (int c = 0; c < bpCycles; c++) begin
      @(negedge clk);
      checkOutput({tag, ".holdValid"}, rsp_valid, 1);
      checkOutput({tag, ".holdId"}, rsp_id, g);
      checkOutput({tag, ".holdSum"}, rsp_sum, expRes[W-1:0]);
      checkOutput({tag, ".holdCarry"}, rsp_carry, expRes[W]);
      checkOutput({tag, ".holdReady"}, req_ready, 0);
      checkOutput({tag, ".holdCount"}, op_count, mCount);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    mCount++;
    checkOutput({tag, ".doneValid"}, rsp_valid, 0);
    checkOutput({tag, ".doneCount"}, op_count, mCount);
    checkOutput({tag, ".doneBusy"}, busy, 0);
  endtask

  // Directed and randomized sequence.
  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    mLast     = NREQ - 1;
    mCount    = 0;
    for (int i = 0; i < NREQ; i++) begin
      opA[i] = '0; opB[i] = '0; opCin[i] = 1'b0; opOp[i] = 1'b0;
    end
    applyStimulus('0);
    #2;
    checkOutput("rst.valid", rsp_valid, 0);
    checkOutput("rst.id", rsp_id, 0);
    checkOutput("rst.sum", rsp_sum, 0);
    checkOutput("rst.carry", rsp_carry, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.count", op_count, 0);
    checkOutput("rst.ready", req_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single add on requester 0.
    opA[0] = 64'd5; opB[0] = 64'd3; opCin[0] = 1'b0; opOp[0] = 1'b0;
    doTransaction(4'b0001, 0, 0, "add");

    // Subtract and arithmetic boundaries on requester 2.
    opA[2] = 64'd5; opB[2] = 64'd3; opCin[2] = 1'b0; opOp[2] = 1'b1;
    doTransaction(4'b0100, 0, 0, "sub");
    opA[2] = 64'd0; opB[2] = 64'd1; opCin[2] = 1'b0; opOp[2] = 1'b1;
    doTransaction(4'b0100, 0, 0, "subUnder");
    opA[2] = 64'd5; opB[2] = 64'd0; opCin[2] = 1'b0; opOp[2] = 1'b1;
    doTransaction(4'b0100, 0, 0, "subZero");
    opA[2] = '1; opB[2] = 64'd1; opCin[2] = 1'b1; opOp[2] = 1'b0;
    doTransaction(4'b0100, 0, 0, "addOvf");

    // Reset while the operation is in EXEC.
    randomizeOperands();
    applyStimulus(4'b1000);
    @(posedge clk);
    #1;
    applyStimulus('0);
    @(negedge clk);
    checkOutput("midRst.preBusy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRst.valid", rsp_valid, 0);
    checkOutput("midRst.count", op_count, 0);
    checkOutput("midRst.busy", busy, 0);
    checkOutput("midRst.ready", req_ready, 0);
    mCount = 0;
    mLast  = NREQ - 1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fairness with every requester asking continuously.
    randomizeOperands();
    for (int t = 0; t < 6; t++) doTransaction(4'b1111, 0, 1, "rr");

    // Backpressure for five cycles.
    randomizeOperands();
    doTransaction(4'b1111, 5, 0, "bp");

    // Randomized traffic.
    for (int t = 0; t < 24; t++) begin
      randomizeOperands();
      doTransaction(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), "rand");
    end
    applyStimulus('0);

    // Priority pointer holds across idle cycles.
    randomizeOperands();
    doTransaction(4'b0010, 0, 0, "hold1");
    repeat (4) begin
      @(negedge clk);
      checkOutput("hold.idleReady", req_ready, 0);
      checkOutput("hold.idleBusy", busy, 0);
    end
    @(posedge clk);
    #1;
    doTransaction(4'b0101, 0, 1, "hold2");
    doTransaction(4'b0101, 0, 0, "hold0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
